// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared UART byte type and FIFO depth default
package uart_tx_fifo_pkg;

    localparam int UART_FIFO_DEPTH = 256;

    typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding uart_tx through a tdata/tvalid/tready handshake
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       wr_data,
    input  logic             wr_en,
    output logic             full,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic [7:0]       tdata,
    output logic             tvalid,
    input  logic             tready
);

    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    uart_byte_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   n_count;
    logic             push;
    logic             pop;

    // push is gated by the registered full, so a pop in the same cycle never frees a slot early
    assign push = wr_en && !full;
    assign pop  = tvalid && tready;

    always_comb begin
        n_count = count;
        if (push && !pop)
            n_count = count + CNT_ONE;
        else if (pop && !push)
            n_count = count - CNT_ONE;
    end

    // storage has no reset and a single write port so it maps onto LUTRAM
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    assign tdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            tvalid   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            count    <= n_count;
            full     <= (n_count == CNT_FULL);
            tvalid   <= (n_count != '0);
            overflow <= overflow || (wr_en && full);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, wr_en, tready, full, overflow, tvalid;
    logic [7:0] wr_data, tdata;
    logic [2:0] count;

    logic       rst_b, wr_en_b, tready_b, full_b, overflow_b, tvalid_b;
    logic [7:0] wr_data_b, tdata_b;
    logic [8:0] count_b;

    uart_tx_fifo #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full),
        .count(count), .overflow(overflow), .tdata(tdata), .tvalid(tvalid), .tready(tready)
    );

    uart_tx_fifo dut_b (
        .clk(clk), .rst(rst_b), .wr_data(wr_data_b), .wr_en(wr_en_b), .full(full_b),
        .count(count_b), .overflow(overflow_b), .tdata(tdata_b), .tvalid(tvalid_b), .tready(tready_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       wr_en;
        logic       tready;
        logic [7:0] wr_data;
        int         cnt;
        logic       tv;
        logic       full;
        logic       ovf;
        logic [7:0] td;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t v(logic r, logic we, logic tr, logic [7:0] d,
                               int c, logic tv, logic f, logic o, logic [7:0] td);
        vec_t x;
        x.rst = r; x.wr_en = we; x.tready = tr; x.wr_data = d;
        x.cnt = c; x.tv = tv; x.full = f; x.ovf = o; x.td = td;
        return x;
    endfunction

    initial begin
        int in_i, out_i, occ, cyc;
        logic do_push, do_pop;

        rst = 1'b1; wr_en = 1'b0; tready = 1'b0; wr_data = 8'h00;
        rst_b = 1'b1; wr_en_b = 1'b0; tready_b = 1'b0; wr_data_b = 8'h00;
        tick();

        //          rst we tr data  cnt tv full ovf tdata
        vt[0]  = v(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        vt[1]  = v(0, 1, 0, 8'h41, 1, 1, 0, 0, 8'h41);
        vt[2]  = v(0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00);
        vt[3]  = v(0, 1, 0, 8'h01, 1, 1, 0, 0, 8'h01);
        vt[4]  = v(0, 1, 0, 8'h02, 2, 1, 0, 0, 8'h01);
        vt[5]  = v(0, 1, 0, 8'h03, 3, 1, 0, 0, 8'h01);
        vt[6]  = v(0, 1, 0, 8'h04, 4, 1, 1, 0, 8'h01);
        vt[7]  = v(0, 1, 0, 8'h05, 4, 1, 1, 1, 8'h01);
        vt[8]  = v(0, 1, 1, 8'h06, 3, 1, 0, 1, 8'h02);
        vt[9]  = v(0, 1, 1, 8'h07, 3, 1, 0, 1, 8'h03);
        vt[10] = v(0, 0, 1, 8'h00, 2, 1, 0, 1, 8'h04);
        vt[11] = v(0, 1, 1, 8'h08, 2, 1, 0, 1, 8'h07);
        vt[12] = v(0, 0, 1, 8'h00, 1, 1, 0, 1, 8'h08);
        vt[13] = v(0, 0, 1, 8'h00, 0, 0, 0, 1, 8'h00);
        vt[14] = v(0, 1, 0, 8'h09, 1, 1, 0, 1, 8'h09);
        vt[15] = v(0, 1, 0, 8'h0A, 2, 1, 0, 1, 8'h09);
        vt[16] = v(0, 1, 0, 8'h0B, 3, 1, 0, 1, 8'h09);
        vt[17] = v(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        vt[18] = v(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        vt[19] = v(0, 1, 0, 8'h0C, 1, 1, 0, 0, 8'h0C);
        vt[20] = v(0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00);

        for (int i = 0; i < 21; i++) begin
            rst = vt[i].rst; wr_en = vt[i].wr_en; tready = vt[i].tready; wr_data = vt[i].wr_data;
            tick();
            chk($sformatf("vec%0d count", i), count, vt[i].cnt);
            chk($sformatf("vec%0d tvalid", i), tvalid, vt[i].tv);
            chk($sformatf("vec%0d full", i), full, vt[i].full);
            chk($sformatf("vec%0d overflow", i), overflow, vt[i].ovf);
            if (vt[i].tv)
                chk($sformatf("vec%0d tdata", i), tdata, vt[i].td);
        end
        rst = 1'b0; wr_en = 1'b0; tready = 1'b0;

        // order and backpressure on the default-depth instance
        rst_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en_b = 1'b1; wr_data_b = 8'(i + 1);
            tick();
        end
        wr_en_b = 1'b0;
        chk("bp count", count_b, 5);
        chk("bp head", tdata_b, 8'h01);
        tick(); tick();
        chk("bp hold tvalid", tvalid_b, 1'b1);
        chk("bp hold tdata", tdata_b, 8'h01);
        for (int k = 0; k < 5; k++) begin
            tick(); tick();
            tready_b = 1'b1;
            chk($sformatf("bp pop%0d tvalid", k), tvalid_b, 1'b1);
            chk($sformatf("bp pop%0d tdata", k), tdata_b, 8'(k + 1));
            tick();
            tready_b = 1'b0;
        end
        chk("bp drained tvalid", tvalid_b, 1'b0);
        chk("bp drained count", count_b, 0);
        chk("bp overflow", overflow_b, 1'b0);

        // push into empty FIFO is not bypassed
        wr_en_b = 1'b1; wr_data_b = 8'h41;
        #1;
        chk("nobypass tvalid", tvalid_b, 1'b0);
        tick();
        wr_en_b = 1'b0;
        chk("nobypass next tvalid", tvalid_b, 1'b1);
        chk("nobypass next tdata", tdata_b, 8'h41);

        // pointer wrap on depth-4 instance: 10 bytes through with occupancy held at 1..3
        rst = 1'b1; tick(); rst = 1'b0;
        in_i = 0; out_i = 0; occ = 0; cyc = 0;
        while (out_i < 10 && cyc < 100) begin
            do_push = (in_i < 10) && (occ < 3);
            do_pop  = (occ >= 2) || (in_i == 10 && occ > 0);
            wr_en = do_push; wr_data = 8'(8'h10 + in_i); tready = do_pop;
            if (do_pop) begin
                chk($sformatf("wrap pop%0d tvalid", out_i), tvalid, 1'b1);
                chk($sformatf("wrap pop%0d tdata", out_i), tdata, 8'(8'h10 + out_i));
                out_i++;
                occ--;
            end
            if (do_push) begin
                in_i++;
                occ++;
            end
            tick();
            chk($sformatf("wrap cyc%0d count", cyc), count, occ);
            cyc++;
        end
        wr_en = 1'b0; tready = 1'b0;
        chk("wrap all popped", out_i, 10);
        chk("wrap final tvalid", tvalid, 1'b0);
        chk("wrap overflow", overflow, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO between the core's output path and `uart_tx`. The core pushes bytes at full clock rate. The FIFO drains them into `uart_tx` through a valid/ready handshake, so program output does not stall on the 115200-baud line rate. It sits directly upstream of `uart_tx`: its `tdata`/`tvalid` connect to the transmitter's inputs, and the transmitter's `tready` feeds back into it.

## Interface
- `DEPTH`, default 256: number of byte entries. Must be a power of two, at least 2.
- `PTR_W`, default `$clog2(DEPTH)`: pointer width. Derived; do not override.
- `clk`  in  1  single system clock.
- `rst`  in  1  synchronous, active-high reset.
- `wr_data`  in  8  byte from the core.
- `wr_en`  in  1  push request, qualified by `!full`.
- `full`  out  1  FIFO holds `DEPTH` entries. Registered.
- `count`  out  PTR_W+1  current occupancy, 0..`DEPTH`. Registered.
- `overflow`  out  1  sticky flag: a push was attempted while `full`. Cleared only by `rst`.
- `tdata`  out  8  head byte to `uart_tx`.
- `tvalid`  out  1  head byte is valid (FIFO not empty).
- `tready`  in  1  `uart_tx` accepts the head byte.

## Operation
- Storage is a circular buffer `mem[DEPTH]` of 8-bit entries, with write pointer `wr_ptr` and read pointer `rd_ptr`, both PTR_W bits.
  - Pointers wrap naturally from `DEPTH-1` to 0.
  - Occupancy is tracked in a separate `count` register.
- Push:
  - `push = wr_en && !full`.
  - On push: `mem[wr_ptr] <= wr_data`, and `wr_ptr` increments.
- Pop:
  - `pop = tvalid && tready`.
  - On pop: `rd_ptr` increments.
- Occupancy update:
  - Push only: `count + 1`.
  - Pop only: `count - 1`.
  - Both, or neither: `count` unchanged.
- Flags are derived from the next-state count and registered:
  - `full <= (n_count == DEPTH)`.
  - `tvalid <= (n_count != 0)`.
- Head data: `tdata = mem[rd_ptr]`, a combinational read of the head entry. It must be stable while `tvalid && !tready`.
- Handshake rules:
  - Once asserted, `tvalid` stays high until a pop. `tdata` does not change until a pop.
  - `tvalid` never depends on `tready` combinationally.
- Full-FIFO behaviour:
  - A push while `full` is dropped, even if a pop occurs in the same cycle. There is no write-through when full.
  - A dropped push sets `overflow` the next cycle.
- Empty-FIFO behaviour:
  - A push into an empty FIFO is not bypassed to `tdata` in the same cycle.
  - `tvalid` rises the following cycle.
- Simultaneous push and pop at non-empty, non-full occupancy: both complete, and `count` holds.
- Mid-transfer reset:
  - `rst` empties the FIFO immediately: pointers, `count`, `tvalid` and `full` go to 0, and `overflow` clears.
  - `mem` contents are not reset.
  - The in-flight byte inside `uart_tx` is that block's concern.

## Timing
- Reset values: `full`=0, `count`=0, `overflow`=0, `tvalid`=0. `tdata` is don't-care while `tvalid`=0.
- Push at cycle N:
  - `count` and `tvalid` update at N+1.
  - The byte is poppable from N+1.
- Pop at cycle N: the next head byte appears on `tdata` at N+1. `tvalid` at N+1 reflects the remaining count.
- Throughput: one push and one pop per cycle, sustained.
- Interaction with `uart_tx`:
  - `tready` is high only when `uart_tx` is idle. After a pop, `uart_tx` holds `tready` low for about 10×`WAIT_DIV` cycles.
  - Back-to-back bytes therefore leave the FIFO with no gap beyond the transmitter's own idle cycle.

## Structure
- Self-contained; no sub-module required.
- The storage array is written so synthesis infers distributed RAM. A single write port and an asynchronous read suit LUTRAM.
- No new shared-package content is needed. If the UART blocks later get a shared package, place the `DEPTH` default and the 8-bit `uart_byte_t` typedef there.
- The top level instantiates `uart_tx_fifo` and `uart_tx` back to back, with `tdata`/`tvalid`/`tready` wired directly.

## Test plan
- **Reset then single push:** after `rst`, push 0x41 for one cycle.
  - Next cycle: `tvalid`=1, `tdata`=0x41, `count`=1.
  - With `tready`=1: pop; `tvalid`=0 one cycle later.
- **Order and backpressure:** push 0x01..0x05 with `tready` held 0.
  - `count`=5 and `tdata` stays 0x01.
  - Then pulse `tready` once per 3 cycles: pops yield 0x01..0x05 in order, then `tvalid`=0.
- **Full and overflow** (`DEPTH`=4): push 5 bytes with `tready`=0.
  - `full`=1 after the 4th push.
  - The 5th push is dropped and `overflow`=1; `count`=4.
  - Draining yields only the first 4 bytes.
- **Simultaneous push/pop:**
  - At `count`=2, push and pop in the same cycle: `count` stays 2 and order is preserved.
  - At `full`, push and pop in the same cycle: the push is dropped, `count`=`DEPTH`-1, and `overflow`=1.
- **Pointer wrap** (`DEPTH`=4): run 10 push/pop pairs of 0x10..0x19 with occupancy 1–3. Output sequence must be exactly 0x10..0x19.
- **Reset mid-operation and end-to-end:**
  - With `count`=3, assert `rst`: next cycle `count`=0, `tvalid`=0, `overflow`=0.
  - Connected to `uart_tx` (`WAIT_DIV`=4): pushing "AB" produces the txd frames 0x41 then 0x42, each with a start bit and a stop bit.
